// File: rtl/fetch_redirect_unit.sv
// Fetch front end: single-outstanding imem requests, decode handshake,
// and EX-stage branch redirect with flush and stale-response drain.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fe_in_ex_valid,
    input  logic        fe_in_branch_en,
    input  logic [31:0] fe_in_branch_target,
    output logic        imem_out_req,
    output logic [31:0] imem_out_addr,
    input  logic        imem_in_ack,
    input  logic        imem_in_rvalid,
    input  logic [31:0] imem_in_rdata,
    output logic        if_out_valid,
    output logic [31:0] if_out_instr,
    output logic [31:0] if_out_pc,
    input  logic        if_in_ready,
    output logic        fe_out_flush
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        redirect;

    // Redirect is masked while reset is held so no flush escapes during reset.
    assign redirect = ~rst & fe_in_ex_valid & fe_in_branch_en;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        if (redirect) begin
            pc_d = {fe_in_branch_target[31:2], 2'b00};
        end
        unique case (state_q)
            S_REQ: begin
                if (imem_in_ack) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_in_rvalid) begin
                    state_d = redirect ? S_REQ : S_HOLD;
                    if (!redirect) begin
                        instr_d = imem_in_rdata;
                        opc_d   = pc_q;
                        pc_d    = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect || if_in_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_in_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_out_req  = ~rst & (state_q == S_REQ);
    assign imem_out_addr = pc_q;
    assign if_out_valid  = ~rst & (state_q == S_HOLD) & ~redirect;
    assign if_out_instr  = instr_q;
    assign if_out_pc     = opc_q;
    assign fe_out_flush  = redirect;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: two instances (reset PC 0 and 0xFFFF_FFFC)
// share stimulus; a transaction-level model predicts every output each cycle.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex = 1'b0, br = 1'b0, ack = 1'b0, rv = 1'b0, rdy = 1'b0;
    logic [31:0] tgt = 32'h0, rd = 32'h0;

    logic        req_o[2], val_o[2], fl_o[2];
    logic [31:0] addr_o[2], ins_o[2], pc_o[2];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst),
        .fe_in_ex_valid(ex), .fe_in_branch_en(br), .fe_in_branch_target(tgt),
        .imem_out_req(req_o[0]), .imem_out_addr(addr_o[0]),
        .imem_in_ack(ack), .imem_in_rvalid(rv), .imem_in_rdata(rd),
        .if_out_valid(val_o[0]), .if_out_instr(ins_o[0]), .if_out_pc(pc_o[0]),
        .if_in_ready(rdy), .fe_out_flush(fl_o[0])
    );

    fetch_redirect_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst),
        .fe_in_ex_valid(ex), .fe_in_branch_en(br), .fe_in_branch_target(tgt),
        .imem_out_req(req_o[1]), .imem_out_addr(addr_o[1]),
        .imem_in_ack(ack), .imem_in_rvalid(rv), .imem_in_rdata(rd),
        .if_out_valid(val_o[1]), .if_out_instr(ins_o[1]), .if_out_pc(pc_o[1]),
        .if_in_ready(rdy), .fe_out_flush(fl_o[1])
    );

    // Model: an accepted request is "outstanding"; "stale" means its data
    // must be thrown away; "have" means an instruction waits for decode.
    logic [31:0] rst_pc[2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] m_pc[2], m_ipc[2], m_ins[2];
    bit          outst, stale, have, minit;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit b,
                         input logic [31:0] t, input bit a, input bit v,
                         input logic [31:0] d, input bit y);
        bit redir;
        @(negedge clk);
        rst = r; ex = e; br = b; tgt = t;
        ack = a; rv = v; rd = d; rdy = y;
        #1;
        redir = !r && e && b;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("req%0d", i), 32'(req_o[i]),
                32'(!r && minit && !outst && !have));
            chk($sformatf("valid%0d", i), 32'(val_o[i]),
                32'(!r && minit && have && !redir));
            chk($sformatf("flush%0d", i), 32'(fl_o[i]), 32'(redir));
            if (minit) begin
                chk($sformatf("addr%0d", i), addr_o[i], m_pc[i]);
                chk($sformatf("instr%0d", i), ins_o[i], m_ins[i]);
                chk($sformatf("pc%0d", i), pc_o[i], m_ipc[i]);
            end
        end
    endtask

    task automatic tick();
        bit redir;
        logic [31:0] npc[2];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i] = rst_pc[i]; m_ipc[i] = 0; m_ins[i] = 0;
            end
            outst = 0; stale = 0; have = 0; minit = 1;
            return;
        end
        redir = ex && br;
        for (int i = 0; i < 2; i++)
            npc[i] = redir ? (tgt & 32'hFFFF_FFFC) : m_pc[i];
        if (have) begin
            if (redir || rdy) have = 0;
        end else if (!outst) begin
            if (ack) begin outst = 1; stale = redir; end
        end else if (rv) begin
            if (!stale && !redir) begin
                have = 1;
                for (int i = 0; i < 2; i++) begin
                    m_ins[i] = rd; m_ipc[i] = m_pc[i]; npc[i] = m_pc[i] + 4;
                end
            end
            outst = 0; stale = 0;
        end else if (redir) begin
            stale = 1;
        end
        for (int i = 0; i < 2; i++) m_pc[i] = npc[i];
    endtask

    initial begin
        // Reset, with a branch pending: no flush may escape
        repeat (3) begin
            drive(1, 1, 1, 32'h40, 0, 0, 0, 0);
            chk("rst_flush", 32'(fl_o[0]), 0);
            tick();
        end
        // First fetch
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t1_addr0", addr_o[0], 32'h0);
        chk("t6_addr1", addr_o[1], 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0050_0093, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t1_valid", 32'(val_o[0]), 1);
        chk("t1_instr", ins_o[0], 32'h0050_0093);
        chk("t6_pc1", pc_o[1], 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_next", addr_o[0], 32'h4);
        chk("t6_wrap", addr_o[1], 32'h0);
        tick();
        // Decode stall
        drive(0, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0); tick();
        repeat (5) begin
            drive(0, 0, 0, 0, 1, 1, 32'hAAAA_5555, 0);
            chk("t2_pc", pc_o[0], 32'h4);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_next", addr_o[0], 32'h8);
        tick();
        // Redirect while waiting for data
        drive(0, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 1, 1, 32'h100, 0, 0, 0, 0);
        chk("t3_flush", 32'(fl_o[0]), 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        chk("t3_drop", 32'(val_o[0]), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_addr", addr_o[0], 32'h100);
        tick();
        // Redirect coincident with ack, unaligned target
        drive(0, 1, 1, 32'h103, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0, 1); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_addr", addr_o[0], 32'h100);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0013, 0); tick();
        // Redirect in HOLD beats ready
        drive(0, 1, 1, 32'h200, 0, 0, 0, 1);
        chk("t4_pc", pc_o[0], 32'h100);
        chk("t6_hold", 32'(val_o[0]), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_tgt", addr_o[0], 32'h200);
        tick();
        // branch_en without ex_valid does nothing
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 32'h300, k[0], k[1], 32'(k), k[2]);
            chk("t5_flush", 32'(fl_o[0]), 0);
            tick();
        end
        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                            : $urandom;
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), t, ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 1) == 1));
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
